// File: rtl/trigger_sequencer.sv
// Trigger sequencer: waits for an armed trigger, applies a tick-counted delay, then emits
// a burst of trig_out pulses with programmable width, period and count.
module trigger_sequencer #(
    parameter int TW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          time_bit,
    input  logic          ext_trig,
    input  logic          sw_trig,
    input  logic          arm,
    input  logic          abort,
    input  logic          mode_cont,
    input  logic [TW-1:0] cfg_delay,
    input  logic [TW-1:0] cfg_width,
    input  logic [TW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_count,
    output logic          trig_out,
    output logic          busy,
    output logic          armed,
    output logic          done,
    output logic [CW-1:0] pulse_cnt
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_DELAY = 3'd2;
    localparam logic [2:0] ST_PULSE = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;

    localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [TW-1:0] pulse_ticks(input logic [TW-1:0] width);
        if (width == TIMER_ZERO) begin
            pulse_ticks = TIMER_ONE;
        end else begin
            pulse_ticks = width;
        end
    endfunction

    function automatic logic [TW-1:0] gap_ticks(input logic [TW-1:0] period,
                                                 input logic [TW-1:0] width);
        if (period > width) begin
            gap_ticks = period - width;
        end else begin
            gap_ticks = TIMER_ONE;
        end
    endfunction

    logic          time_bit_q_r, arm_q_r;
    logic          ext_sync1_r, ext_sync2_r, ext_q_r;
    logic          tick_s, arm_rise_s, ext_edge_s, fire_s;
    logic [2:0]    state_r, state_nxt_s;
    logic [TW-1:0] timer_r, timer_nxt_s;
    logic [TW-1:0] width_r, width_nxt_s, period_r, period_nxt_s;
    logic [CW-1:0] count_r, count_nxt_s, pulse_cnt_r, pulse_cnt_nxt_s;

    // Input conditioning: tick and arm edge detectors, two-flop synchronizer for the external pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_bit_q_r <= 1'b0;
            arm_q_r      <= 1'b0;
            ext_sync1_r  <= 1'b0;
            ext_sync2_r  <= 1'b0;
            ext_q_r      <= 1'b0;
        end else begin
            time_bit_q_r <= time_bit;
            arm_q_r      <= arm;
            ext_sync1_r  <= ext_trig;
            ext_sync2_r  <= ext_sync1_r;
            ext_q_r      <= ext_sync2_r;
        end
    end

    assign tick_s     = time_bit & ~time_bit_q_r;
    assign arm_rise_s = arm & ~arm_q_r;
    assign ext_edge_s = ext_sync2_r & ~ext_q_r;
    assign fire_s     = ext_edge_s | sw_trig;

    // Next-state, timer and burst-counter logic; abort has priority over everything
    always_comb begin
        state_nxt_s     = state_r;
        timer_nxt_s     = timer_r;
        pulse_cnt_nxt_s = pulse_cnt_r;
        width_nxt_s     = width_r;
        period_nxt_s    = period_r;
        count_nxt_s     = count_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = TIMER_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm_rise_s) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (fire_s) begin
                        state_nxt_s     = ST_DELAY;
                        timer_nxt_s     = cfg_delay;
                        pulse_cnt_nxt_s = CNT_ZERO;
                        width_nxt_s     = cfg_width;
                        period_nxt_s    = cfg_period;
                        count_nxt_s     = cfg_count;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_DELAY: begin
                    if (timer_r == TIMER_ZERO) begin
                        state_nxt_s = ST_PULSE;
                        timer_nxt_s = pulse_ticks(width_r);
                    end else if (tick_s) begin
                        timer_nxt_s = timer_r - TIMER_ONE;
                    end else begin
                        timer_nxt_s = timer_r;
                    end
                end
                ST_PULSE: begin
                    // A timer already at zero is treated as expired so the FSM can never stall here
                    if (tick_s && (timer_r <= TIMER_ONE)) begin
                        pulse_cnt_nxt_s = pulse_cnt_r + CNT_ONE;
                        if ((count_r != CNT_ZERO) && (pulse_cnt_nxt_s == count_r)) begin
                            state_nxt_s = ST_END;
                            timer_nxt_s = TIMER_ZERO;
                        end else begin
                            state_nxt_s = ST_GAP;
                            timer_nxt_s = gap_ticks(period_r, width_r);
                        end
                    end else if (tick_s) begin
                        timer_nxt_s = timer_r - TIMER_ONE;
                    end else begin
                        timer_nxt_s = timer_r;
                    end
                end
                ST_GAP: begin
                    if (tick_s && (timer_r <= TIMER_ONE)) begin
                        state_nxt_s = ST_PULSE;
                        timer_nxt_s = pulse_ticks(width_r);
                    end else if (tick_s) begin
                        timer_nxt_s = timer_r - TIMER_ONE;
                    end else begin
                        timer_nxt_s = timer_r;
                    end
                end
                ST_END: begin
                    if (mode_cont) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = TIMER_ZERO;
                end
            endcase
        end
    end

    // FSM state, timer, configuration snapshot and pulse counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            timer_r     <= TIMER_ZERO;
            width_r     <= TIMER_ZERO;
            period_r    <= TIMER_ZERO;
            count_r     <= CNT_ZERO;
            pulse_cnt_r <= CNT_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            width_r     <= width_nxt_s;
            period_r    <= period_nxt_s;
            count_r     <= count_nxt_s;
            pulse_cnt_r <= pulse_cnt_nxt_s;
        end
    end

    // Status outputs decoded from the next state so they are registered and aligned with state_r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_out <= 1'b0;
            busy     <= 1'b0;
            armed    <= 1'b0;
            done     <= 1'b0;
        end else begin
            trig_out <= (state_nxt_s == ST_PULSE);
            busy     <= (state_nxt_s == ST_DELAY) || (state_nxt_s == ST_PULSE) ||
                        (state_nxt_s == ST_GAP);
            armed    <= (state_nxt_s == ST_ARMED);
            done     <= (state_nxt_s == ST_END);
        end
    end

    assign pulse_cnt = pulse_cnt_r;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural burst model.
module tb_trigger_sequencer;

    localparam int TW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          time_bit = 1'b0;
    logic          ext_trig = 1'b0;
    logic          sw_trig = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          mode_cont = 1'b0;
    logic [TW-1:0] cfg_delay = '0;
    logic [TW-1:0] cfg_width = '0;
    logic [TW-1:0] cfg_period = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          trig_out, busy, armed, done;
    logic [CW-1:0] pulse_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    trigger_sequencer #(.TW(TW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .time_bit(time_bit), .ext_trig(ext_trig),
        .sw_trig(sw_trig), .arm(arm), .abort(abort), .mode_cont(mode_cont),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
        .cfg_count(cfg_count), .trig_out(trig_out), .busy(busy), .armed(armed),
        .done(done), .pulse_cnt(pulse_cnt)
    );

    initial forever #5 clk = ~clk;

    // time_bit toggles every 2 clk, so one tick every 4 clk
    initial forever begin
        repeat (2) @(posedge clk);
        #1 time_bit = ~time_bit;
    end

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_ARMED, M_DELAY, M_PULSE, M_GAP, M_END} mph_t;
    mph_t m_ph = M_IDLE;
    int   m_seen = 0, m_len = 0, m_cnt = 0, m_w = 0, m_p = 0, m_c = 0;
    bit   m_tb_prev = 0, m_arm_prev = 0, m_e1 = 0, m_e2 = 0, m_e3 = 0;

    function automatic int at_least_one(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_step();
        bit tick, arm_rise, fire;
        if (!rst_n) begin
            m_ph = M_IDLE; m_seen = 0; m_len = 0; m_cnt = 0;
            m_tb_prev = 0; m_arm_prev = 0; m_e1 = 0; m_e2 = 0; m_e3 = 0;
            return;
        end
        tick     = time_bit && !m_tb_prev;
        arm_rise = arm && !m_arm_prev;
        // pin level is seen by the fire logic two edges after it is first sampled
        fire     = (m_e2 && !m_e3) || sw_trig;
        m_tb_prev = time_bit; m_arm_prev = arm;
        m_e3 = m_e2; m_e2 = m_e1; m_e1 = ext_trig;
        if (abort) begin
            m_ph = M_IDLE;
        end else begin
            case (m_ph)
                M_IDLE:  if (arm_rise) m_ph = M_ARMED;
                M_ARMED: if (fire) begin
                    m_ph = M_DELAY; m_len = int'(cfg_delay); m_seen = 0; m_cnt = 0;
                    m_w = int'(cfg_width); m_p = int'(cfg_period); m_c = int'(cfg_count);
                end
                M_DELAY: begin
                    if (m_seen >= m_len) begin
                        m_ph = M_PULSE; m_len = at_least_one(m_w); m_seen = 0;
                    end else if (tick) begin
                        m_seen++;
                    end
                end
                M_PULSE: if (tick) begin
                    m_seen++;
                    if (m_seen == m_len) begin
                        m_cnt++; m_seen = 0;
                        if (m_c != 0 && m_cnt == m_c) m_ph = M_END;
                        else begin
                            m_ph = M_GAP; m_len = (m_p > m_w) ? m_p - m_w : 1;
                        end
                    end
                end
                M_GAP: if (tick) begin
                    m_seen++;
                    if (m_seen == m_len) begin
                        m_ph = M_PULSE; m_len = at_least_one(m_w); m_seen = 0;
                    end
                end
                M_END:   m_ph = mode_cont ? M_ARMED : M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // every-cycle comparison of all outputs against the model
    initial forever begin
        logic [CW+3:0] exp_v, act_v;
        @(negedge clk);
        if (cmp_en) begin
            exp_v = {m_ph == M_PULSE, (m_ph == M_DELAY) || (m_ph == M_PULSE) || (m_ph == M_GAP),
                     m_ph == M_ARMED, m_ph == M_END, CW'(m_cnt)};
            act_v = {trig_out, busy, armed, done, pulse_cnt};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t {trig,busy,armed,done,cnt} got %h expected %h",
                         $time, act_v, exp_v);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1; step(1); arm = 1'b0; step(1);
    endtask

    task automatic fire_sw();
        sw_trig = 1'b1; step(1); sw_trig = 1'b0;
    endtask

    task automatic set_cfg(input int d, input int w, input int p, input int c);
        cfg_delay = TW'(d); cfg_width = TW'(w); cfg_period = TW'(p); cfg_count = CW'(c);
    endtask

    // Follow a burst until the cycle after done; cycle 0 is the first edge after the call
    task automatic observe(input int max_cyc, output int npulse, output int first_start,
                           output int first_w, output int last_w, output int s2s,
                           output int ndone);
        int run, last_start;
        bit prev, seen_done, finished;
        npulse = 0; first_start = -1; first_w = 0; last_w = 0; s2s = 0; ndone = 0;
        run = 0; last_start = 0; prev = 0; seen_done = 0; finished = 0;
        for (int c = 0; c < max_cyc && !finished; c++) begin
            step(1);
            if (trig_out && !prev) begin
                npulse++;
                if (npulse == 1) first_start = c;
                if (npulse == 2) s2s = c - last_start;
                last_start = c; run = 0;
            end
            if (trig_out) run++;
            if (!trig_out && prev) begin
                if (npulse == 1) first_w = run;
                last_w = run;
            end
            if (done) begin ndone++; seen_done = 1; end
            else if (seen_done) finished = 1;
            prev = trig_out;
        end
        if (!finished) begin
            n_tests++; n_fail++;
            $display("FAIL observe_timeout: burst did not end within %0d cycles", max_cyc);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int np, fs, fw, lw, s2s, nd, lat, cnt;
        bit prev, hit;

        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        step(3);
        check("reset_trig", trig_out, 0);
        check("reset_busy", busy, 0);
        check("reset_armed", armed, 0);
        check("reset_done", done, 0);
        check("reset_cnt", pulse_cnt, 0);
        rst_n = 1'b1;
        step(2);

        // 1: two pulses, width 3 ticks, period 5 ticks
        set_cfg(2, 3, 5, 2);
        arm_pulse();
        check("t1_armed", armed, 1);
        fire_sw();
        observe(300, np, fs, fw, lw, s2s, nd);
        check("t1_npulse", np, 2);
        check_range("t1_first_width", fw, 9, 12);
        check("t1_second_width", lw, 12);
        check_range("t1_start_to_start", s2s, 17, 20);
        check("t1_done_cycles", nd, 1);
        check("t1_pulse_cnt", pulse_cnt, 2);
        check("t1_idle_armed", armed, 0);
        check("t1_idle_busy", busy, 0);

        // 2: zero delay, zero width -> one 1-tick pulse two clk after sw_trig
        set_cfg(0, 0, 0, 1);
        arm_pulse();
        fire_sw();
        check("t2_busy_after_fire", busy, 1);
        check("t2_trig_low_in_delay", trig_out, 0);
        observe(100, np, fs, fw, lw, s2s, nd);
        check("t2_first_start", fs, 0);
        check("t2_npulse", np, 1);
        check_range("t2_width", fw, 1, 4);
        check("t2_done_cycles", nd, 1);
        check("t2_pulse_cnt", pulse_cnt, 1);

        // 3: external trigger latency, then a second edge during the burst is ignored
        set_cfg(2, 1, 0, 1);
        arm_pulse();
        ext_trig = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            step(1);
            if (busy) lat = k;
        end
        check("t3_ext_latency", lat, 3);
        ext_trig = 1'b0; step(2); ext_trig = 1'b1;
        observe(100, np, fs, fw, lw, s2s, nd);
        check("t3_done_cycles", nd, 1);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin step(1); if (busy) cnt++; end
        check("t3_no_retrigger", cnt, 0);
        check("t3_pulse_cnt", pulse_cnt, 1);
        ext_trig = 1'b0;

        // 4: continuous mode re-arms without a new arm edge
        mode_cont = 1'b1;
        set_cfg(0, 1, 0, 1);
        arm_pulse();
        fire_sw();
        observe(100, np, fs, fw, lw, s2s, nd);
        check("t4_done_cycles", nd, 1);
        check("t4_rearmed", armed, 1);
        fire_sw();
        check("t4_refire_busy", busy, 1);
        observe(100, np, fs, fw, lw, s2s, nd);
        check("t4_second_npulse", np, 1);
        check("t4_still_armed", armed, 1);
        abort = 1'b1; step(1); abort = 1'b0;
        check("t4_abort_idle", armed, 0);
        mode_cont = 1'b0;

        // 5: endless burst, abort in the middle of the third pulse
        set_cfg(1, 2, 4, 0);
        arm_pulse();
        fire_sw();
        cnt = 0; prev = 0;
        for (int k = 0; k < 200 && cnt < 3; k++) begin
            step(1);
            if (trig_out && !prev) cnt++;
            prev = trig_out;
        end
        check("t5_pulses_seen", cnt, 3);
        abort = 1'b1; step(1); abort = 1'b0;
        check("t5_abort_trig", trig_out, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_armed", armed, 0);
        check("t5_cnt_held", pulse_cnt, 2);

        // 7: pulse counter wraps in endless mode
        set_cfg(0, 1, 1, 0);
        arm_pulse();
        fire_sw();
        hit = 0;
        for (int k = 0; k < 3000 && !hit; k++) begin step(1); if (pulse_cnt == 8'hff) hit = 1; end
        check("t7_reach_255", int'(hit), 1);
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin step(1); if (pulse_cnt == 8'h00) hit = 1; end
        check("t7_wrap_to_0", int'(hit), 1);
        check("t7_still_busy", busy, 1);
        abort = 1'b1; step(1); abort = 1'b0;

        // 6: asynchronous reset mid-pulse, then sw_trig without arm does nothing
        set_cfg(0, 5, 8, 0);
        arm_pulse();
        fire_sw();
        hit = 0;
        for (int k = 0; k < 50 && !hit; k++) begin step(1); if (trig_out) hit = 1; end
        check("t6_pulse_started", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_trig_drop", trig_out, 0);
        check("t6_async_busy_drop", busy, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        fire_sw();
        cnt = 0;
        for (int k = 0; k < 12; k++) begin step(1); if (trig_out || busy) cnt++; end
        check("t6_no_pulse_without_arm", cnt, 0);
        check("t6_not_armed", armed, 0);

        // random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 31) == 0) begin
                set_cfg($urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 6), $urandom_range(0, 3));
                mode_cont = 1'($urandom_range(0, 1));
            end
            arm     = ($urandom_range(0, 7) == 0);
            sw_trig = ($urandom_range(0, 11) == 0);
            abort   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) ext_trig = ~ext_trig;
            step(1);
        end
        arm = 1'b0; sw_trig = 1'b0; abort = 1'b0; ext_trig = 1'b0;
        step(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
